// File: rtl/twpm_pkg.sv
// rtl/twpm_pkg.sv - shared register map, FSM encoding and constants for the TPM command bridge
package twpm_pkg;

    localparam logic [7:0] REG_STATUS     = 8'h00;
    localparam logic [7:0] REG_OP_TYPE    = 8'h04;
    localparam logic [7:0] REG_LOCALITY   = 8'h08;
    localparam logic [7:0] REG_BUF_SIZE   = 8'h0C;
    localparam logic [7:0] REG_IRQ_STATUS = 8'h10;
    localparam logic [7:0] REG_IRQ_EN     = 8'h14;
    localparam logic [7:0] REG_COMPLETE   = 8'h40;

    localparam logic [31:0] TWPM_DEFAULT_READ = 32'hBADFABAC;

    localparam int IRQ_EXEC_BIT  = 0;
    localparam int IRQ_ABORT_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_BUSY     = 2'd2,
        ST_COMPLETE = 2'd3
    } twpm_state_e;

endpackage

// File: rtl/twpm_sync_edge.sv
// rtl/twpm_sync_edge.sv - N-stage synchroniser with a registered rising-edge flag
module twpm_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic wb_clk,
    input  logic rstn_i,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              q_d;

    always_ff @(posedge wb_clk or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= '0;
            q_d    <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            q_d    <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~q_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/twpm_cmd_bridge.sv
// rtl/twpm_cmd_bridge.sv - Wishbone control/status bridge between the LPC TPM register file and the CPU
module twpm_cmd_bridge
    import twpm_pkg::*;
#(
    parameter int          RAM_ADDR_WIDTH     = 11,
    parameter int          SYNC_STAGES        = 2,
    parameter int          COMPLETE_MIN       = 20,
    parameter int          COMPLETE_MAX       = 4095,
    parameter logic [31:0] DEFAULT_READ_VALUE = TWPM_DEFAULT_READ
) (
    input  logic                      wb_clk,
    input  logic                      rstn_i,
    input  logic [16:0]               wb_adr_i,
    input  logic [31:0]               wb_dat_i,
    output logic [31:0]               wb_dat_o,
    input  logic                      wb_we_i,
    input  logic [3:0]                wb_sel_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_cyc_i,
    output logic                      wb_ack_o,
    input  logic                      exec_i,
    input  logic                      abort_i,
    input  logic [3:0]                op_type_i,
    input  logic [3:0]                locality_i,
    input  logic [RAM_ADDR_WIDTH-1:0] buf_len_i,
    output logic                      complete_o,
    output logic                      ram_owner_o,
    output logic                      irq_o
);

    localparam int CNT_W = $clog2(COMPLETE_MAX + 1);

    logic exec_s, exec_rise, abort_s, abort_rise;

    twpm_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_exec (
        .wb_clk (wb_clk),
        .rstn_i (rstn_i),
        .d      (exec_i),
        .q      (exec_s),
        .rise   (exec_rise)
    );

    twpm_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_abort (
        .wb_clk (wb_clk),
        .rstn_i (rstn_i),
        .d      (abort_i),
        .q      (abort_s),
        .rise   (abort_rise)
    );

    assign ram_owner_o = exec_s;

    logic                      window, bus_req, wr_en;
    logic [RAM_ADDR_WIDTH-1:0] byte_off;
    logic                      wr_complete, wr_irq_status, wr_irq_en;

    assign window        = (wb_adr_i[16:RAM_ADDR_WIDTH] == '0);
    assign bus_req       = wb_cyc_i & wb_stb_i & window & ~wb_ack_o;
    assign wr_en         = bus_req & wb_we_i & wb_sel_i[0];
    assign byte_off      = {wb_adr_i[RAM_ADDR_WIDTH-1:2], 2'b00};
    assign wr_complete   = wr_en & (byte_off == RAM_ADDR_WIDTH'(REG_COMPLETE));
    assign wr_irq_status = wr_en & (byte_off == RAM_ADDR_WIDTH'(REG_IRQ_STATUS));
    assign wr_irq_en     = wr_en & (byte_off == RAM_ADDR_WIDTH'(REG_IRQ_EN));

    logic unused_bus_bits;
    assign unused_bus_bits = ^{wb_sel_i[3:1], wb_dat_i[31:2], wb_adr_i[1:0]};

    always_ff @(posedge wb_clk or negedge rstn_i) begin
        if (!rstn_i) wb_ack_o <= 1'b0;
        else         wb_ack_o <= bus_req;
    end

    twpm_state_e state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             snap_load, set_exec, cnt_done;

    assign cnt_done = (!exec_s && (cnt >= CNT_W'(COMPLETE_MIN - 1))) ||
                      (cnt == CNT_W'(COMPLETE_MAX));

    always_ff @(posedge wb_clk or negedge rstn_i) begin
        if (!rstn_i) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Abort and an early exec drop take priority over a completion request.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (exec_rise) state_nxt = ST_SETTLE;
            ST_SETTLE:   state_nxt = (abort_rise || !exec_s) ? ST_IDLE : ST_BUSY;
            ST_BUSY: begin
                if (abort_rise || !exec_s) state_nxt = ST_IDLE;
                else if (wr_complete)      state_nxt = ST_COMPLETE;
            end
            ST_COMPLETE: if (cnt_done) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        complete_o = 1'b0;
        snap_load  = 1'b0;
        set_exec   = 1'b0;
        case (state)
            ST_SETTLE: begin
                snap_load = 1'b1;
                set_exec  = 1'b1;
            end
            ST_COMPLETE: complete_o = 1'b1;
            default: ;
        endcase
    end

    // Counter sits at zero outside COMPLETE so entry always starts the hold time from 0.
    always_ff @(posedge wb_clk or negedge rstn_i) begin
        if (!rstn_i)                          cnt <= '0;
        else if (state != ST_COMPLETE)        cnt <= '0;
        else if (cnt != CNT_W'(COMPLETE_MAX)) cnt <= cnt + 1'b1;
    end

    logic [3:0]                snap_op, snap_loc;
    logic [RAM_ADDR_WIDTH-1:0] snap_len;

    always_ff @(posedge wb_clk or negedge rstn_i) begin
        if (!rstn_i) begin
            snap_op  <= '0;
            snap_loc <= '0;
            snap_len <= '0;
        end else if (snap_load) begin
            snap_op  <= op_type_i;
            snap_loc <= locality_i;
            snap_len <= buf_len_i;
        end
    end

    logic [1:0] pend, pend_nxt, irq_en, irq_en_nxt;

    // Sets are applied after the W1C so a coincident set wins.
    always_comb begin
        pend_nxt = pend;
        if (wr_irq_status) pend_nxt = pend & ~wb_dat_i[1:0];
        if (set_exec)      pend_nxt[IRQ_EXEC_BIT]  = 1'b1;
        if (abort_rise)    pend_nxt[IRQ_ABORT_BIT] = 1'b1;
        irq_en_nxt = wr_irq_en ? wb_dat_i[1:0] : irq_en;
    end

    always_ff @(posedge wb_clk or negedge rstn_i) begin
        if (!rstn_i) begin
            pend   <= '0;
            irq_en <= '0;
            irq_o  <= 1'b0;
        end else begin
            pend   <= pend_nxt;
            irq_en <= irq_en_nxt;
            irq_o  <= |(pend_nxt & irq_en_nxt);
        end
    end

    always_comb begin
        wb_dat_o = DEFAULT_READ_VALUE;
        case (byte_off)
            RAM_ADDR_WIDTH'(REG_STATUS):
                wb_dat_o = {27'b0, pend[IRQ_ABORT_BIT], pend[IRQ_EXEC_BIT], complete_o, abort_s, exec_s};
            RAM_ADDR_WIDTH'(REG_OP_TYPE):    wb_dat_o = 32'(snap_op);
            RAM_ADDR_WIDTH'(REG_LOCALITY):   wb_dat_o = 32'(snap_loc);
            RAM_ADDR_WIDTH'(REG_BUF_SIZE):   wb_dat_o = 32'(snap_len);
            RAM_ADDR_WIDTH'(REG_IRQ_STATUS): wb_dat_o = {30'b0, pend};
            RAM_ADDR_WIDTH'(REG_IRQ_EN):     wb_dat_o = {30'b0, irq_en};
            RAM_ADDR_WIDTH'(REG_COMPLETE):   wb_dat_o = 32'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_twpm_cmd_bridge.sv
// tb/tb_twpm_cmd_bridge.sv - directed self-checking bench for twpm_cmd_bridge
module tb_twpm_cmd_bridge;

    logic        wb_clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic [16:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_we_i = 1'b0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_ack_o;
    logic        exec_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [3:0]  op_type_i = '0;
    logic [3:0]  locality_i = '0;
    logic [10:0] buf_len_i = '0;
    logic        complete_o;
    logic        ram_owner_o;
    logic        irq_o;

    int n_cmp = 0;
    int n_bad = 0;
    int hi;

    always #5 wb_clk = ~wb_clk;

    twpm_cmd_bridge dut (
        .wb_clk      (wb_clk),
        .rstn_i      (rstn_i),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_dat_o    (wb_dat_o),
        .wb_we_i     (wb_we_i),
        .wb_sel_i    (wb_sel_i),
        .wb_stb_i    (wb_stb_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_ack_o    (wb_ack_o),
        .exec_i      (exec_i),
        .abort_i     (abort_i),
        .op_type_i   (op_type_i),
        .locality_i  (locality_i),
        .buf_len_i   (buf_len_i),
        .complete_o  (complete_o),
        .ram_owner_o (ram_owner_o),
        .irq_o       (irq_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [16:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        @(negedge wb_clk);
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(negedge wb_clk);
        check("write_ack", wb_ack_o, 1);
        wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_sel_i = '0;
    endtask

    task automatic read_check(input string tag, input logic [16:0] adr, input logic [31:0] exp);
        @(negedge wb_clk);
        wb_adr_i = adr; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(negedge wb_clk);
        check({tag, "_ack"}, wb_ack_o, 1);
        check(tag, wb_dat_o, exp);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    endtask

    task automatic start_cmd(input logic [3:0] op, input logic [3:0] loc, input logic [10:0] len);
        @(negedge wb_clk);
        op_type_i = op; locality_i = loc; buf_len_i = len; exec_i = 1'b1;
        repeat (8) @(negedge wb_clk);
    endtask

    // Counts complete_o high cycles from the current negedge; drop_at < 0 keeps exec high.
    task automatic measure_complete(input int drop_at, input int limit, output int cycles);
        cycles = 0;
        for (int i = 0; i < limit; i++) begin
            if (!complete_o) break;
            cycles++;
            if (i == drop_at) exec_i = 1'b0;
            @(negedge wb_clk);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge wb_clk);
        check("rst_complete", complete_o, 0);
        check("rst_owner", ram_owner_o, 0);
        check("rst_irq", irq_o, 0);
        check("rst_ack", wb_ack_o, 0);
        rstn_i = 1'b1;
        read_check("rst_status", 17'h00000, 32'h0);
        read_check("rst_irq_en", 17'h00014, 32'h0);
        read_check("rst_op", 17'h00004, 32'h0);

        // New command: snapshots, owner, exec IRQ
        wb_write(17'h00014, 32'h1, 4'h1);
        start_cmd(4'h1, 4'h2, 11'h00A);
        check("owner_busy", ram_owner_o, 1);
        check("irq_exec", irq_o, 1);
        read_check("status_busy", 17'h00000, 32'h09);
        read_check("op_type", 17'h00004, 32'h1);
        read_check("locality", 17'h00008, 32'h2);
        read_check("buf_size", 17'h0000C, 32'h00A);

        // W1C of pend_exec; writes without sel[0] are ignored
        wb_write(17'h00010, 32'h1, 4'h1);
        check("irq_cleared", irq_o, 0);
        read_check("status_w1c", 17'h00000, 32'h01);
        wb_write(17'h00014, 32'h3, 4'h2);
        read_check("irq_en_sel0", 17'h00014, 32'h1);

        // Completion with exec dropping early: 20-cycle minimum hold
        wb_write(17'h00040, 32'h1, 4'h1);
        check("complete_set", complete_o, 1);
        measure_complete(2, 200, hi);
        check("complete_min_len", hi, 20);
        check("owner_released", ram_owner_o, 0);
        read_check("status_idle", 17'h00000, 32'h00);
        wb_write(17'h00040, 32'h1, 4'h1);
        check("complete_in_idle", complete_o, 0);

        // Completion with exec held: timeout after 4096 cycles, max buf_len
        start_cmd(4'h3, 4'h4, 11'h7FF);
        read_check("buf_size_max", 17'h0000C, 32'h7FF);
        wb_write(17'h00040, 32'h1, 4'h1);
        measure_complete(-1, 5000, hi);
        check("complete_timeout_len", hi, 4096);
        check("owner_after_timeout", ram_owner_o, 1);
        read_check("status_after_timeout", 17'h00000, 32'h09);
        @(negedge wb_clk);
        exec_i = 1'b0;
        repeat (4) @(negedge wb_clk);
        wb_write(17'h00010, 32'h3, 4'h1);

        // Abort during BUSY
        start_cmd(4'h5, 4'h0, 11'h100);
        abort_i = 1'b1;
        repeat (3) @(negedge wb_clk);
        abort_i = 1'b0;
        repeat (6) @(negedge wb_clk);
        check("abort_no_complete", complete_o, 0);
        read_check("status_abort", 17'h00000, 32'h19);
        read_check("op_after_abort", 17'h00004, 32'h5);
        wb_write(17'h00040, 32'h1, 4'h1);
        check("complete_after_abort", complete_o, 0);
        repeat (3) @(negedge wb_clk);
        check("complete_after_abort_late", complete_o, 0);
        wb_write(17'h00010, 32'h1, 4'h1);
        check("irq_abort_masked", irq_o, 0);
        wb_write(17'h00014, 32'h2, 4'h1);
        check("irq_abort_enabled", irq_o, 1);
        read_check("irq_status_abort", 17'h00010, 32'h2);
        read_check("irq_en_abort", 17'h00014, 32'h2);
        @(negedge wb_clk);
        exec_i = 1'b0;
        repeat (4) @(negedge wb_clk);

        // Undecoded read with stb held: single-cycle ack
        @(negedge wb_clk);
        wb_adr_i = 17'h00020; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(negedge wb_clk);
        check("default_ack", wb_ack_o, 1);
        check("default_data", wb_dat_o, 32'hBADFABAC);
        @(negedge wb_clk);
        check("default_ack_single", wb_ack_o, 0);
        wb_adr_i = 17'h00800;
        @(negedge wb_clk);
        check("ram_window_no_ack", wb_ack_o, 0);
        @(negedge wb_clk);
        check("ram_window_no_ack2", wb_ack_o, 0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;

        // Reset while in COMPLETE
        start_cmd(4'h7, 4'h1, 11'h020);
        wb_write(17'h00040, 32'h1, 4'h1);
        repeat (3) @(negedge wb_clk);
        check("complete_before_rst", complete_o, 1);
        read_check("status_complete", 17'h00000, 32'h1D);
        @(negedge wb_clk);
        rstn_i = 1'b0;
        #1;
        check("rst_mid_complete", complete_o, 0);
        check("rst_mid_owner", ram_owner_o, 0);
        check("rst_mid_irq", irq_o, 0);
        repeat (2) @(negedge wb_clk);
        exec_i = 1'b0;
        rstn_i = 1'b1;
        read_check("status_after_rst", 17'h00000, 32'h0);
        read_check("op_after_rst", 17'h00004, 32'h0);
        read_check("irq_en_after_rst", 17'h00014, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
